// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//   Shares one 32-bit Y86-64 ALU between two requesters (0: execute stage,
//   1: address / stack-pointer update path) with round-robin arbitration and
//   valid/ready handshakes. Each accepted result is registered into a single
//   response slot tagged with the issuing requester's ID.
//
//   Optional feature macro: ALU_ARBITER_CC_EN
//     defined   -> condition-code register {ZF, SF, OF} is kept, updated by
//                  accepted operations that have setcc=1, reset to 3'b100.
//     undefined -> no cc flops, cc tied to 3'b000, setcc inputs ignored.
//
// Parameters
//   PRIO_INIT    requester that holds priority after reset (0 or 1)
//
// Ports
//   clk          clock, rising edge
//   rst_n        synchronous active-low reset
//   reqN_valid   requester N offers an operation
//   reqN_ready   requester N's operation is accepted this cycle
//   reqN_ctrl    ALU op: 00 add, 01 sub (a-b), 10 and, 11 xor
//   reqN_a/b     32-bit signed operands
//   reqN_setcc   update condition codes from this operation
//   rsp_valid    response slot full
//   rsp_ready    consumer takes the response
//   rsp_id       requester that issued the response
//   rsp_data     ALU result
//   rsp_ovf      signed overflow of the result
//   cc           {ZF, SF, OF}
// ---------------------------------------------------------------------------

// Combinational Y86-64 style ALU: wrap-around two's complement arithmetic,
// overflow flagged only for add/sub.
module alu (
  input  logic [1:0]  control,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] ans,
  output logic        overflow
);

  logic [31:0] w_sum;
  logic [31:0] w_diff;
  logic        w_sum_ovf;
  logic        w_diff_ovf;

  assign w_sum  = a + b;
  assign w_diff = a - b;

  // Add overflows when both operands share a sign the result does not;
  // subtract overflows when the operands differ in sign and the result
  // takes the subtrahend's sign.
  assign w_sum_ovf  = (a[31] == b[31]) && (w_sum[31]  != a[31]);
  assign w_diff_ovf = (a[31] != b[31]) && (w_diff[31] != a[31]);

  always_comb begin
    ans      = 32'd0;
    overflow = 1'b0;
    case (control)
      2'b00: begin
        ans      = w_sum;
        overflow = w_sum_ovf;
      end
      2'b01: begin
        ans      = w_diff;
        overflow = w_diff_ovf;
      end
      2'b10: ans = a & b;
      default: ans = a ^ b;
    endcase
  end

endmodule

module alu_arbiter #(
  parameter bit PRIO_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [1:0]  req0_ctrl,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_setcc,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [1:0]  req1_ctrl,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_setcc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        rsp_ovf,
  output logic [2:0]  cc
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } slot_state_t;

  slot_state_t r_state;
  slot_state_t w_state_next;
  logic        r_prio;
  logic        w_prio_next;

  logic        r_rsp_id;
  logic [31:0] r_rsp_data;
  logic        r_rsp_ovf;

  logic        w_slot_free;
  logic        w_any_valid;
  logic        w_grant;
  logic        w_accept;
  logic [1:0]  w_ctrl;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic [31:0] w_ans;
  logic        w_ovf;

  // The slot can take a new result when empty or when it is being drained
  // in this same cycle.
  assign w_slot_free = (r_state == S_EMPTY) | rsp_ready;
  assign w_any_valid = req0_valid | req1_valid;

  // With only one requester valid, it wins outright (req1_valid alone selects
  // 1, req0_valid alone selects 0); under contention the priority holder wins.
  assign w_grant = (req0_valid & req1_valid) ? r_prio : req1_valid;

  // rst_n gates accept so nothing is handshaken during reset.
  assign w_accept   = rst_n & w_any_valid & w_slot_free;
  assign req0_ready = w_accept & ~w_grant;
  assign req1_ready = w_accept &  w_grant;

  assign w_ctrl = w_grant ? req1_ctrl : req0_ctrl;
  assign w_a    = w_grant ? req1_a    : req0_a;
  assign w_b    = w_grant ? req1_b    : req0_b;

  alu u_alu (
    .control  (w_ctrl),
    .a        (w_a),
    .b        (w_b),
    .ans      (w_ans),
    .overflow (w_ovf)
  );

  // Slot FSM plus priority toggle: state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
      r_prio  <= PRIO_INIT;
    end else begin
      r_state <= w_state_next;
      r_prio  <= w_prio_next;
    end
  end

  // Slot FSM plus priority toggle: next state. Priority moves to the
  // requester that was not served, which gives strict alternation under
  // continuous contention.
  always_comb begin
    w_state_next = r_state;
    w_prio_next  = r_prio;
    case (r_state)
      S_EMPTY: begin
        if (w_accept) begin
          w_state_next = S_FULL;
          w_prio_next  = ~w_grant;
        end
      end
      default: begin
        if (w_accept) begin
          // Drain and refill in the same cycle keeps the slot full.
          w_state_next = S_FULL;
          w_prio_next  = ~w_grant;
        end else if (rsp_ready) begin
          w_state_next = S_EMPTY;
        end
      end
    endcase
  end

  // Response payload only changes on accept, so it holds stable under
  // back-pressure and keeps its last value after draining.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_id   <= 1'b0;
      r_rsp_data <= 32'd0;
      r_rsp_ovf  <= 1'b0;
    end else if (w_accept) begin
      r_rsp_id   <= w_grant;
      r_rsp_data <= w_ans;
      r_rsp_ovf  <= w_ovf;
    end
  end

  assign rsp_valid = (r_state == S_FULL);
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_ovf   = r_rsp_ovf;

`ifdef ALU_ARBITER_CC_EN
  logic [2:0] r_cc;
  logic       w_setcc;

  assign w_setcc = w_grant ? req1_setcc : req0_setcc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cc <= 3'b100;
    end else if (w_accept && w_setcc) begin
      r_cc <= {(w_ans == 32'd0), w_ans[31], w_ovf};
    end
  end

  assign cc = r_cc;
`else
  // setcc has no effect without the condition-code register.
  logic w_unused_setcc;
  assign w_unused_setcc = req0_setcc ^ req1_setcc;
  assign cc = 3'b000;
`endif

endmodule
